// File: rtl/apb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// apb_mem_arbiter
//
// Shares the core's single APB master port between three requesters:
//   0 = instruction fetch, 1 = load/store data, 2 = DMA/debug.
//
// A registered IDLE/SETUP/ACCESS APB master issues one transfer at a time.
// Arbitration happens in IDLE:
//   - requester 1 always beats requester 0 (the CPU group),
//   - the CPU group and requester 2 alternate when both are asking.
// Each transfer ends with a one-cycle m_ready or m_err pulse to the granted
// requester. m_err is raised by pslverr or by a wait-state timeout.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   m_req[2:0]      request level per requester (held until its pulse)
//   m_we[2:0]       1 = write, 0 = read, per requester
//   m_addr          packed addresses, requester i at [i*AW +: AW]
//   m_wdata         packed write data, requester i at [i*DW +: DW]
//   m_strb          packed byte strobes, requester i at [i*DW/8 +: DW/8]
//   rdata           read data of the last completed read (shared)
//   m_ready[2:0]    one-cycle completion pulse
//   m_err[2:0]      one-cycle error pulse (pslverr or timeout)
//   psel, penable, pwrite, paddr, pwdata, pstrb   APB master outputs
//   prdata, pready, pslverr                       APB slave responses
// ----------------------------------------------------------------------------
module apb_mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            m_req,
    input  logic [2:0]            m_we,
    input  logic [3*AW-1:0]       m_addr,
    input  logic [3*DW-1:0]       m_wdata,
    input  logic [3*(DW/8)-1:0]   m_strb,
    output logic [DW-1:0]         rdata,
    output logic [2:0]            m_ready,
    output logic [2:0]            m_err,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [AW-1:0]         paddr,
    output logic [DW-1:0]         pwdata,
    output logic [DW/8-1:0]       pstrb,
    input  logic [DW-1:0]         prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    localparam int SW    = DW / 8;
    // Counter only needs to reach TIMEOUT; keep at least one bit when
    // the timeout is disabled.
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam bit TO_EN = (TIMEOUT != 0);
    localparam logic [CNT_W:0] TO_VAL = (CNT_W + 1)'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;

    // Arbitration results
    logic              cpu_req;
    logic [1:0]        cpu_pick;
    logic [1:0]        pick;
    logic              grant_vld;

    // Winner's payload
    logic [AW-1:0]     sel_addr;
    logic [DW-1:0]     sel_wdata;
    logic [SW-1:0]     sel_strb;
    logic              sel_we;
    logic [2:0]        sel_oh;

    // Transfer bookkeeping
    logic [2:0]        gnt_oh;
    logic              last_dma;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W:0]    cnt_inc;
    logic              timeout_hit;

    // ------------------------------------------------------------------
    // Arbitration. Skipped while a pulse is out: the requester that just
    // finished still shows its req in that cycle, and must not be
    // re-granted on a stale request.
    // ------------------------------------------------------------------
    always_comb begin
        cpu_req  = m_req[0] | m_req[1];
        cpu_pick = m_req[1] ? 2'd1 : 2'd0;
        pick     = 2'd0;
        if (cpu_req && m_req[2]) begin
            // Both sides asking: give it to the side not served last.
            pick = last_dma ? cpu_pick : 2'd2;
        end else if (cpu_req) begin
            pick = cpu_pick;
        end else if (m_req[2]) begin
            pick = 2'd2;
        end
        grant_vld = (state == S_IDLE) && (|m_req) && !(|m_ready) && !(|m_err);
    end

    // Payload mux for the winning requester
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_strb  = '0;
        sel_we    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (pick == i[1:0]) begin
                sel_addr  = m_addr[i*AW +: AW];
                sel_wdata = m_wdata[i*DW +: DW];
                sel_strb  = m_strb[i*SW +: SW];
                sel_we    = m_we[i];
            end
        end
        sel_oh = 3'b001 << pick;
    end

    // Wait-state timeout: fires on the ACCESS cycle that brings the count
    // of pready=0 cycles up to TIMEOUT.
    always_comb begin
        cnt_inc     = {1'b0, cnt} + (CNT_W + 1)'(1);
        timeout_hit = TO_EN && (state == S_ACCESS) && !pready && (cnt_inc == TO_VAL);
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (grant_vld) begin
                    state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                if (pready || timeout_hit) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. psel/penable decode straight from the state register,
    // so they are glitch-free and drop in the same cycle as the pulse.
    // ------------------------------------------------------------------
    always_comb begin
        psel    = (state == S_SETUP) || (state == S_ACCESS);
        penable = (state == S_ACCESS);
    end

    // ------------------------------------------------------------------
    // Transfer registers: APB payload, pulses, read data, fairness and
    // timeout bookkeeping. The payload is captured only at grant, so
    // later changes on the requester side have no effect.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pwrite   <= 1'b0;
            paddr    <= '0;
            pwdata   <= '0;
            pstrb    <= '0;
            rdata    <= '0;
            m_ready  <= '0;
            m_err    <= '0;
            gnt_oh   <= '0;
            last_dma <= 1'b0;
            cnt      <= '0;
        end else begin
            m_ready <= '0;
            m_err   <= '0;
            case (state)
                S_IDLE: begin
                    if (grant_vld) begin
                        gnt_oh <= sel_oh;
                        paddr  <= sel_addr;
                        pwrite <= sel_we;
                        pwdata <= sel_wdata;
                        pstrb  <= sel_we ? sel_strb : '0;
                        cnt    <= '0;
                    end
                end
                S_ACCESS: begin
                    if (pready) begin
                        if (!pwrite) begin
                            rdata <= prdata;
                        end
                        if (pslverr) begin
                            m_err <= gnt_oh;
                        end else begin
                            m_ready <= gnt_oh;
                        end
                        last_dma <= gnt_oh[2];
                    end else if (timeout_hit) begin
                        m_err <= gnt_oh;
                    end else begin
                        cnt <= cnt_inc[CNT_W-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_mem_arbiter.sv
module tb_apb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [2:0]          m_req = '0;
    logic [2:0]          m_we = '0;
    logic [3*AW-1:0]     m_addr = '0;
    logic [3*DW-1:0]     m_wdata = '0;
    logic [3*SW-1:0]     m_strb = '0;
    logic [DW-1:0]       rdata;
    logic [2:0]          m_ready;
    logic [2:0]          m_err;
    logic                psel;
    logic                penable;
    logic                pwrite;
    logic [AW-1:0]       paddr;
    logic [DW-1:0]       pwdata;
    logic [SW-1:0]       pstrb;
    logic [DW-1:0]       prdata = '0;
    logic                pready = 1'b1;
    logic                pslverr = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    apb_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_strb  (m_strb),
        .rdata   (rdata),
        .m_ready (m_ready),
        .m_err   (m_err),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .pstrb   (pstrb),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits up to 12 cycles for any pulse; idx = pulsing requester.
    task automatic wait_pulse(output int idx, output bit ok);
        ok  = 1'b0;
        idx = -1;
        for (int k = 0; k < 12; k++) begin
            tick();
            if ((|m_ready) || (|m_err)) begin
                ok = 1'b1;
                for (int j = 0; j < 3; j++) begin
                    if (m_ready[j] || m_err[j]) idx = j;
                end
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_tests++;
        if ({psel, penable, pwrite} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctrl: psel/penable/pwrite=%b expected 000", {psel, penable, pwrite});
        end
        n_tests++;
        if (paddr !== '0 || pwdata !== '0 || pstrb !== '0 || rdata !== '0) begin
            n_fail++;
            $display("FAIL reset_data: paddr=%h pwdata=%h pstrb=%h rdata=%h expected all 0",
                     paddr, pwdata, pstrb, rdata);
        end
        n_tests++;
        if (m_ready !== 3'b000 || m_err !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_pulses: m_ready=%b m_err=%b expected 000/000", m_ready, m_err);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_read_zero_wait();
        // c0
        m_we = 3'b000;
        m_addr[0*AW +: AW] = 32'h0000_0100;
        m_req = 3'b001;
        prdata = 32'hDEAD_BEEF;
        pready = 1'b1;
        tick(); // c1
        n_tests++;
        if (psel !== 1'b1 || penable !== 1'b0 || paddr !== 32'h100 || pwrite !== 1'b0 || pstrb !== 4'h0) begin
            n_fail++;
            $display("FAIL read_setup: psel=%b penable=%b paddr=%h pwrite=%b pstrb=%h expected 1 0 100 0 0",
                     psel, penable, paddr, pwrite, pstrb);
        end
        tick(); // c2
        n_tests++;
        if (psel !== 1'b1 || penable !== 1'b1 || m_ready !== 3'b000) begin
            n_fail++;
            $display("FAIL read_access: psel=%b penable=%b m_ready=%b expected 1 1 000", psel, penable, m_ready);
        end
        tick(); // c3
        n_tests++;
        if (m_ready !== 3'b001 || m_err !== 3'b000 || psel !== 1'b0) begin
            n_fail++;
            $display("FAIL read_done: m_ready=%b m_err=%b psel=%b expected 001 000 0", m_ready, m_err, psel);
        end
        n_tests++;
        if (rdata !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL read_rdata: rdata=%h expected deadbeef", rdata);
        end
        m_req = 3'b000;
        tick(); // c4
        n_tests++;
        if (m_ready !== 3'b000 || psel !== 1'b0) begin
            n_fail++;
            $display("FAIL read_pulse_width: m_ready=%b psel=%b expected 000 0", m_ready, psel);
        end
    endtask

    task automatic test_write_strobes();
        // c0
        m_we = 3'b010;
        m_addr[1*AW +: AW]  = 32'h0000_2004;
        m_wdata[1*DW +: DW] = 32'h0000_55AA;
        m_strb[1*SW +: SW]  = 4'b0011;
        m_req = 3'b010;
        pready = 1'b0;
        prdata = 32'h1234_5678;
        tick(); // c1 SETUP
        n_tests++;
        if (psel !== 1'b1 || penable !== 1'b0 || pwrite !== 1'b1 || paddr !== 32'h2004 ||
            pwdata !== 32'h55AA || pstrb !== 4'b0011) begin
            n_fail++;
            $display("FAIL write_setup: psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h pstrb=%b expected 1 0 1 2004 55aa 0011",
                     psel, penable, pwrite, paddr, pwdata, pstrb);
        end
        // Payload changes after grant must not reach the bus.
        m_addr[1*AW +: AW]  = 32'h000F_FFF0;
        m_wdata[1*DW +: DW] = 32'hFFFF_FFFF;
        for (int k = 0; k < 3; k++) begin
            tick(); // c2, c3, c4 ACCESS
            n_tests++;
            if (psel !== 1'b1 || penable !== 1'b1 || pwrite !== 1'b1 || paddr !== 32'h2004 ||
                pwdata !== 32'h55AA || pstrb !== 4'b0011 || m_ready !== 3'b000) begin
                n_fail++;
                $display("FAIL write_hold[%0d]: psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h pstrb=%b m_ready=%b expected 1 1 1 2004 55aa 0011 000",
                         k, psel, penable, pwrite, paddr, pwdata, pstrb, m_ready);
            end
            if (k == 2) pready = 1'b1;
        end
        tick(); // c5
        n_tests++;
        if (m_ready !== 3'b010 || m_err !== 3'b000 || psel !== 1'b0) begin
            n_fail++;
            $display("FAIL write_done: m_ready=%b m_err=%b psel=%b expected 010 000 0", m_ready, m_err, psel);
        end
        n_tests++;
        if (rdata !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL write_rdata: rdata=%h expected deadbeef (unchanged)", rdata);
        end
        m_req = 3'b000;
        m_we  = 3'b000;
        tick(); // c6
        n_tests++;
        if (m_ready !== 3'b000) begin
            n_fail++;
            $display("FAIL write_once: m_ready=%b expected 000", m_ready);
        end
    endtask

    task automatic test_slverr();
        m_we = 3'b000;
        m_addr[2*AW +: AW] = 32'h0000_0300;
        m_req = 3'b100;
        pready = 1'b1;
        pslverr = 1'b1;
        tick();
        tick();
        tick(); // c3
        n_tests++;
        if (m_err !== 3'b100 || m_ready !== 3'b000) begin
            n_fail++;
            $display("FAIL slverr: m_err=%b m_ready=%b expected 100 000", m_err, m_ready);
        end
        m_req = 3'b000;
        pslverr = 1'b0;
        tick();
        n_tests++;
        if (m_err !== 3'b000) begin
            n_fail++;
            $display("FAIL slverr_width: m_err=%b expected 000", m_err);
        end
    endtask

    task automatic test_contention();
        int exp1[4] = '{1, 2, 1, 2};
        int exp2[3] = '{0, 2, 0};
        int idx;
        bit ok;
        m_we = 3'b000;
        m_addr[0*AW +: AW] = 32'h0000_0A00;
        m_addr[1*AW +: AW] = 32'h0000_0B00;
        m_addr[2*AW +: AW] = 32'h0000_0C00;
        pready = 1'b1;
        m_req = 3'b111;
        for (int n = 0; n < 4; n++) begin
            wait_pulse(idx, ok);
            n_tests++;
            if (!ok || idx != exp1[n] || m_err !== 3'b000) begin
                n_fail++;
                $display("FAIL contention_all[%0d]: served=%0d ok=%0b m_err=%b expected requester %0d",
                         n, idx, ok, m_err, exp1[n]);
            end
        end
        m_req = 3'b101;
        for (int n = 0; n < 3; n++) begin
            wait_pulse(idx, ok);
            n_tests++;
            if (!ok || idx != exp2[n]) begin
                n_fail++;
                $display("FAIL contention_02[%0d]: served=%0d ok=%0b expected requester %0d",
                         n, idx, ok, exp2[n]);
            end
        end
        m_req = 3'b000;
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        // Requester 1 held: pulses must be exactly 4 cycles apart.
        int gap;
        bit seen;
        m_we = 3'b000;
        pready = 1'b1;
        m_req = 3'b010;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (m_ready[1]) begin
                seen = 1'b1;
                break;
            end
        end
        gap = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (m_ready[1]) begin
                gap = k;
                break;
            end
        end
        n_tests++;
        if (!seen || gap != 4) begin
            n_fail++;
            $display("FAIL back_to_back: gap=%0d first_seen=%0b expected gap 4", gap, seen);
        end
        m_req = 3'b000;
        tick();
        tick();
    endtask

    task automatic test_timeout();
        m_we = 3'b000;
        m_req = 3'b001;
        pready = 1'b0;
        tick(); // c1
        for (int k = 0; k < 4; k++) begin
            tick(); // c2..c5
            n_tests++;
            if (psel !== 1'b1 || penable !== 1'b1 || m_err !== 3'b000) begin
                n_fail++;
                $display("FAIL timeout_wait[%0d]: psel=%b penable=%b m_err=%b expected 1 1 000",
                         k, psel, penable, m_err);
            end
        end
        tick(); // c6
        n_tests++;
        if (m_err !== 3'b001 || m_ready !== 3'b000 || psel !== 1'b0 || penable !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_abort: m_err=%b m_ready=%b psel=%b penable=%b expected 001 000 0 0",
                     m_err, m_ready, psel, penable);
        end
        m_req = 3'b000;
        pready = 1'b1;
        tick();
    endtask

    task automatic test_reset_in_access();
        m_we = 3'b010;
        m_addr[1*AW +: AW]  = 32'h0000_2004;
        m_wdata[1*DW +: DW] = 32'h0000_55AA;
        m_strb[1*SW +: SW]  = 4'b0011;
        m_req = 3'b010;
        pready = 1'b0;
        tick(); // c1
        tick(); // c2 ACCESS
        n_tests++;
        if (penable !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_access_pre: penable=%b expected 1", penable);
        end
        pready = 1'b1;   // would complete now without the reset
        rst = 1'b1;
        tick(); // c3
        n_tests++;
        if ({psel, penable, pwrite} !== 3'b000 || paddr !== '0 || pwdata !== '0 || pstrb !== '0 ||
            m_ready !== 3'b000 || m_err !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_access: psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h pstrb=%b m_ready=%b m_err=%b expected all 0",
                     psel, penable, pwrite, paddr, pwdata, pstrb, m_ready, m_err);
        end
        rst = 1'b0;
        tick(); // c4 SETUP of the retried grant
        n_tests++;
        if (psel !== 1'b1 || penable !== 1'b0 || paddr !== 32'h2004) begin
            n_fail++;
            $display("FAIL rst_regrant_setup: psel=%b penable=%b paddr=%h expected 1 0 2004", psel, penable, paddr);
        end
        tick(); // c5 ACCESS
        tick(); // c6
        n_tests++;
        if (m_ready !== 3'b010) begin
            n_fail++;
            $display("FAIL rst_regrant_done: m_ready=%b expected 010", m_ready);
        end
        m_req = 3'b000;
        tick();
    endtask

    initial begin
        test_reset();
        test_read_zero_wait();
        test_write_strobes();
        test_slverr();
        test_contention();
        test_back_to_back();
        test_timeout();
        test_reset_in_access();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
